examp_req_source: RTL and testbench

EXAMP_REQ_SOURCE -- requirements
Module: examp_req_source

---
 rtl/examp_if_pkg.sv | 11 +
 rtl/examp_req_fifo.sv | 62 ++++++
 rtl/examp_req_source.sv | 155 +++++++++++++++
 tb/tb_examp_req_source.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/examp_if_pkg.sv
// Shared definitions for the examp request path: data width and request FSM states.
package examp_if_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } req_state_e;

endpackage

// File: rtl/examp_req_fifo.sv
// Request buffer: DEPTH x W FIFO exposing the head word and the word behind it.
module examp_req_fifo
  import examp_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_dat,
  output logic [W-1:0]               rd_dat,
  output logic [W-1:0]               nxt_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;
  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign rd_dat  = mem_r[rd_ptr_r];
  assign nxt_dat = mem_r[rd_ptr_r + AW'(1)];

  // Storage array; no reset needed since occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/examp_req_source.sv
// Request source: buffers upstream words and presents each until acknowledged.
// Optional wait timeout is compiled in with EXAMP_REQ_TIMEOUT_EN.
module examp_req_source
  import examp_if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  input  logic [DATA_W-1:0] in_dat,
  output logic              in_rdy,
  output logic              req_val,
  output logic [DATA_W-1:0] req_dat,
  input  logic              out,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CW = $clog2(DEPTH + 1);

  req_state_e        state_r;
  req_state_e        state_nxt_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     count_nxt_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] nxt_s;
  logic [DATA_W-1:0] load_dat_s;
  logic [DATA_W-1:0] req_dat_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              ack_s;
  logic              tmo_s;
  logic              pop_s;
  logic              load_s;
  logic              req_val_s;
  logic              in_rdy_r;
  logic              busy_r;

  assign req_val_s   = (state_r == DRIVE);
  assign push_s      = in_val & in_rdy_r & ~full_s;
  assign ack_s       = req_val_s & out;
  assign pop_s       = ack_s | tmo_s;
  assign count_nxt_s = count_s + CW'(push_s) - CW'(pop_s);

  assign in_rdy  = in_rdy_r;
  assign req_val = req_val_s;
  assign req_dat = req_dat_r;
  assign busy    = busy_r;

  examp_req_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_dat  (in_dat),
    .rd_dat  (head_s),
    .nxt_dat (nxt_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

`ifdef EXAMP_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_r;
  logic          err_r;

  // Acknowledge wins over an expiring wait on the same edge.
  assign tmo_s       = req_val_s & ~out & (tmo_cnt_r == TW'(TIMEOUT - 1));
  assign err_timeout = err_r;

  // Wait counter: restarts with each word presented, advances while unacknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (load_s || tmo_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else if (req_val_s) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      err_r <= tmo_s;
    end
  end
`else
  assign tmo_s       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next state and word to present; a word pushed while the last one completes is bypassed.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_dat_s  = head_s;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nxt_s = DRIVE;
          load_s      = 1'b1;
          load_dat_s  = head_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (ack_s && (count_nxt_s != {CW{1'b0}})) begin
          state_nxt_s = DRIVE;
          load_s      = 1'b1;
          if (count_s == CW'(1)) begin
            load_dat_s = in_dat;
          end else begin
            load_dat_s = nxt_s;
          end
        end else if (pop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, computed from post-edge occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      req_dat_r <= {DATA_W{1'b0}};
      in_rdy_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        req_dat_r <= load_dat_s;
      end else begin
        req_dat_r <= req_dat_r;
      end
      in_rdy_r <= (count_nxt_s != CW'(DEPTH));
      busy_r   <= (count_nxt_s != {CW{1'b0}}) | (state_nxt_s == DRIVE);
    end
  end

endmodule

// File: tb/tb_examp_req_source.sv
// Self-checking bench for examp_req_source: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_examp_req_source;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;
`ifdef EXAMP_REQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val;
  logic [7:0] in_dat;
  logic       in_rdy;
  logic       req_val;
  logic [7:0] req_dat;
  logic       out;
  logic       busy;
  logic       err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: queue holds every word not yet completed, head is the presented one
  logic [7:0] q[$];
  logic       m_val;
  logic [7:0] m_dat;
  logic       m_rdy;
  logic       m_busy;
  logic       m_err;
  int         m_wait;
  int         pv;
  int         po;

  always #5 clk = ~clk;

  examp_req_source #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_val      (in_val),
    .in_dat      (in_dat),
    .in_rdy      (in_rdy),
    .req_val     (req_val),
    .req_dat     (req_dat),
    .out         (out),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_val  = 1'b0;
    m_dat  = 8'h00;
    m_rdy  = 1'b0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_wait = 0;
  endtask

  task automatic model_edge();
    bit push;
    bit ack;
    bit tmo;
    int old_n;
    if (rst) begin
      model_reset();
      return;
    end
    push  = in_val && m_rdy;
    ack   = m_val && out;
    tmo   = TMO_EN && m_val && !out && (m_wait == TMO - 1);
    old_n = q.size();
    if (ack || tmo) void'(q.pop_front());
    if (push) q.push_back(in_dat);
    if (!m_val) begin
      if (old_n > 0) begin
        m_val  = 1'b1;
        m_dat  = q[0];
        m_wait = 0;
      end
    end else if (ack) begin
      if (q.size() > 0) begin
        m_dat  = q[0];
        m_wait = 0;
      end else begin
        m_val = 1'b0;
      end
    end else if (tmo) begin
      m_val  = 1'b0;
      m_wait = 0;
    end else begin
      m_wait++;
    end
    m_rdy  = (q.size() < DEPTH);
    m_busy = (q.size() != 0) || m_val;
    m_err  = tmo;
  endtask

  task automatic compare();
    check("in_rdy", 32'(in_rdy), 32'(m_rdy));
    check("req_val", 32'(req_val), 32'(m_val));
    if (m_val) check("req_dat", 32'(req_dat), 32'(m_dat));
    check("busy", 32'(busy), 32'(m_busy));
    check("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare();
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_val = 1'b0;
    in_dat = 8'h00;
    out    = 1'b0;
    model_reset();
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_req_val", 32'(req_val), 32'd0);
    check("rst_req_dat", 32'(req_dat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    check("rdy_after_rst", 32'(in_rdy), 32'd1);

    // single word
    in_val = 1'b1; in_dat = 8'hA5;
    step(1);
    in_val = 1'b0;
    step(1);
    check("single_val", 32'(req_val), 32'd1);
    check("single_dat", 32'(req_dat), 32'hA5);
    step(2);
    out = 1'b1;
    step(1);
    out = 1'b0;
    check("single_done_val", 32'(req_val), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);

    // spurious acknowledge while idle
    out = 1'b1;
    step(2);
    out = 1'b0; in_val = 1'b1; in_dat = 8'h77;
    step(1);
    in_val = 1'b0;
    step(3);
    check("spur_hold_val", 32'(req_val), 32'd1);
    check("spur_hold_dat", 32'(req_dat), 32'h77);
    out = 1'b1;
    step(1);
    out = 1'b0;
    check("spur_done", 32'(req_val), 32'd0);

    // back-to-back with acknowledge tied high
    out = 1'b1; in_val = 1'b1; in_dat = 8'h01;
    step(1);
    in_dat = 8'h02;
    step(1);
    check("b2b_dat1", 32'(req_dat), 32'h01);
    in_dat = 8'h03;
    step(1);
    check("b2b_dat2", 32'(req_dat), 32'h02);
    check("b2b_val2", 32'(req_val), 32'd1);
    in_val = 1'b0;
    step(1);
    check("b2b_dat3", 32'(req_dat), 32'h03);
    check("b2b_val3", 32'(req_val), 32'd1);
    step(1);
    check("b2b_end", 32'(req_val), 32'd0);
    out = 1'b0;

    // full: five pushes, fifth refused
    in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dat = 8'(8'h10 + i);
      step(1);
    end
    check("full_rdy", 32'(in_rdy), 32'd0);
    in_dat = 8'h14;
    step(1);
    check("full_rdy_hold", 32'(in_rdy), 32'd0);
    in_val = 1'b0; out = 1'b1;
    step(1);
    out = 1'b0;
    check("full_rdy_after_ack", 32'(in_rdy), 32'd1);
    check("full_next_dat", 32'(req_dat), 32'h11);

    // asynchronous reset with three words queued and a request outstanding
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_req_val", 32'(req_val), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_rdy", 32'(in_rdy), 32'd0);
    step(1);
    rst = 1'b0;
    step(3);
    check("arst_no_stale", 32'(req_val), 32'd0);
    check("arst_idle_busy", 32'(busy), 32'd0);

`ifdef EXAMP_REQ_TIMEOUT_EN
    // timeout drop, gap, next word; then acknowledge on the expiring edge
    in_val = 1'b1; in_dat = 8'h3C;
    step(1);
    in_dat = 8'h3D;
    step(1);
    in_val = 1'b0;
    step(3);
    check("tmo_not_yet", 32'(err_timeout), 32'd0);
    step(1);
    check("tmo_pulse", 32'(err_timeout), 32'd1);
    check("tmo_gap", 32'(req_val), 32'd0);
    step(1);
    check("tmo_next_val", 32'(req_val), 32'd1);
    check("tmo_next_dat", 32'(req_dat), 32'h3D);
    check("tmo_pulse_end", 32'(err_timeout), 32'd0);
    step(3);
    out = 1'b1;
    step(1);
    out = 1'b0;
    check("tmo_ack_prio", 32'(err_timeout), 32'd0);
    check("tmo_ack_done", 32'(req_val), 32'd0);
`else
    // without the timeout a word waits indefinitely
    in_val = 1'b1; in_dat = 8'h3C;
    step(1);
    in_val = 1'b0;
    step(20);
    check("notmo_hold_val", 32'(req_val), 32'd1);
    check("notmo_hold_dat", 32'(req_dat), 32'h3C);
    check("notmo_err", 32'(err_timeout), 32'd0);
    out = 1'b1;
    step(1);
    out = 1'b0;
`endif

    // random traffic with varying push/ack densities and occasional resets
    for (int ph = 0; ph < 6; ph++) begin
      pv = $urandom_range(10, 90);
      po = $urandom_range(5, 95);
      for (int c = 0; c < 500; c++) begin
        in_val = ($urandom_range(0, 99) < pv);
        in_dat = 8'($urandom);
        out    = ($urandom_range(0, 99) < po);
        if ($urandom_range(0, 399) == 0) begin
          #2;
          rst = 1'b1;
          #1;
          model_reset();
          compare();
          step(1);
          rst = 1'b0;
        end
        step(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
